// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the two-read/one-write register file:
// sequencer state encoding and the power-up value of each register.
package regfile_2r1w_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Mode 0 loads each register with its own index, mode 1 clears everything.
    function automatic logic [31:0] init_value(input logic [31:0] index, input logic mode);
        return mode ? 32'd0 : index;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset initialisation sequencer: walks every register once, then
// parks in RUN and raises ready_o.
module regfile_init_seq #(
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int DATA_W    = 8,
    parameter int INIT_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic [DATA_W-1:0] init_data_o,
    output logic              ready_o
);
    import regfile_2r1w_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_we_o   = (state_q == ST_INIT) && !rst_i;
    assign init_addr_o = cnt_q;
    assign init_data_o = DATA_W'(init_value(32'(cnt_q), INIT_MODE != 0));
    assign ready_o     = (state_q == ST_RUN);

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with optional x0 hardwiring, write-to-read
// bypass and a per-register busy scoreboard for decode-stage hazard checks.
module regfile_2r1w #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              ready
);
    import regfile_2r1w_pkg::*;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;

    logic              run_wr, run_rsv, hit_a, hit_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    function automatic logic addr_writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_init_seq #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_data_o (init_data),
        .ready_o     (ready)
    );

    // Traffic is only honoured once the sequencer has finished.
    assign run_wr  = ready && we && addr_writable(waddr);
    assign run_rsv = ready && rsv_en && addr_writable(rsv_addr);
    assign hit_a   = (BYPASS != 0) && run_wr && (waddr == raddr_a);
    assign hit_b   = (BYPASS != 0) && run_wr && (waddr == raddr_b);

    assign wr_en   = ready ? run_wr : init_we;
    assign wr_addr = ready ? waddr  : init_addr;
    assign wr_data = ready ? wdata  : init_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Reserve is applied after the write clear so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (run_wr) begin
            busy_d[waddr] = 1'b0;
        end
        if (run_rsv) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdata_a = '0;
        busy_a  = 1'b0;
        if (ready) begin
            if (hit_a) begin
                rdata_a = wdata;
            end else if (addr_writable(raddr_a)) begin
                rdata_a = mem_q[raddr_a];
                busy_a  = busy_q[raddr_a];
            end
        end
    end

    always_comb begin
        rdata_b = '0;
        busy_b  = 1'b0;
        if (ready) begin
            if (hit_b) begin
                rdata_b = wdata;
            end else if (addr_writable(raddr_b)) begin
                rdata_b = mem_q[raddr_b];
                busy_b  = busy_q[raddr_b];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vectors, reset/init sequences, a random
// run against an array-based reference, and a 32x32 clear-init variant.
module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] raddr_a, raddr_b, waddr, rsv_addr;
    logic       we, rsv_en;
    logic [7:0] wdata;
    logic [7:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic       busy_a, busy_b, nb_busy_a, nb_busy_b, ready, nb_ready;

    logic        rst2, w_we, w_rsv_en, w_busy_a, w_busy_b, w_ready;
    logic [4:0]  w_raddr_a, w_raddr_b, w_waddr, w_rsv_addr;
    logic [31:0] w_wdata, w_rdata_a, w_rdata_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .clk(clk), .rst(rst), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy_a(busy_a), .busy_b(busy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .ready(ready)
    );

    regfile_2r1w #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b), .busy_a(nb_busy_a), .busy_b(nb_busy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .ready(nb_ready)
    );

    regfile_2r1w #(.DATA_W(32), .NUM_REGS(32), .INIT_MODE(1)) dut_w (
        .clk(clk), .rst(rst2), .raddr_a(w_raddr_a), .raddr_b(w_raddr_b),
        .rdata_a(w_rdata_a), .rdata_b(w_rdata_b), .busy_a(w_busy_a), .busy_b(w_busy_b),
        .we(w_we), .waddr(w_waddr), .wdata(w_wdata), .rsv_en(w_rsv_en),
        .rsv_addr(w_rsv_addr), .ready(w_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       we;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic       rsv_en;
        logic [2:0] rsv_addr;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea;
        logic       eba;
        logic [7:0] eb;
        logic       ebb;
        logic [7:0] enb;
    } vec_t;

    function automatic vec_t mk(input int we_i, input int wa, input int wd, input int rs,
                                input int rsa, input int ra, input int rb, input int ea,
                                input int eba, input int eb, input int ebb, input int enb);
        vec_t v;
        v.we = 1'(we_i); v.waddr = 3'(wa); v.wdata = 8'(wd);
        v.rsv_en = 1'(rs); v.rsv_addr = 3'(rsa);
        v.ra = 3'(ra); v.rb = 3'(rb);
        v.ea = 8'(ea); v.eba = 1'(eba); v.eb = 8'(eb); v.ebb = 1'(ebb); v.enb = 8'(enb);
        return v;
    endfunction

    // Reference model state
    logic [7:0] m_mem [8];
    logic       m_busy [8];
    int         m_init_left;

    task automatic model_read(input logic [2:0] ra, input logic byp,
                              output logic [7:0] d, output logic b);
        d = 8'h00;
        b = 1'b0;
        if (m_init_left == 0) begin
            if (byp && we && waddr != 3'd0 && waddr == ra) begin
                d = wdata;
            end else if (ra != 3'd0) begin
                d = m_mem[ra];
                b = m_busy[ra];
            end
        end
    endtask

    vec_t tv [12];

    initial begin
        logic [7:0] ed;
        logic       eb;

        rst = 1'b1; we = 1'b0; rsv_en = 1'b0; waddr = '0; wdata = '0;
        rsv_addr = '0; raddr_a = 3'd3; raddr_b = 3'd5;
        rst2 = 1'b1; w_we = 1'b0; w_rsv_en = 1'b0; w_waddr = '0; w_wdata = '0;
        w_rsv_addr = '0; w_raddr_a = '0; w_raddr_b = '0;

        tv[0]  = mk(0, 0, 8'h00, 0, 0, 3, 7, 8'h03, 0, 8'h07, 0, 8'h03);
        tv[1]  = mk(1, 3, 8'hA5, 0, 0, 3, 3, 8'hA5, 0, 8'hA5, 0, 8'h03);
        tv[2]  = mk(0, 0, 8'h00, 1, 5, 3, 5, 8'hA5, 0, 8'h05, 0, 8'hA5);
        tv[3]  = mk(0, 0, 8'h00, 0, 0, 5, 5, 8'h05, 1, 8'h05, 1, 8'h05);
        tv[4]  = mk(1, 5, 8'h3C, 0, 0, 5, 2, 8'h3C, 0, 8'h02, 0, 8'h05);
        tv[5]  = mk(1, 5, 8'h77, 1, 5, 5, 5, 8'h77, 0, 8'h77, 0, 8'h3C);
        tv[6]  = mk(0, 0, 8'h00, 0, 0, 5, 0, 8'h77, 1, 8'h00, 0, 8'h77);
        tv[7]  = mk(1, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        tv[8]  = mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 8'h01, 0, 8'h00);
        tv[9]  = mk(1, 6, 8'h11, 1, 2, 6, 2, 8'h11, 0, 8'h02, 0, 8'h06);
        tv[10] = mk(0, 0, 8'h00, 1, 4, 2, 6, 8'h02, 1, 8'h11, 0, 8'h02);
        tv[11] = mk(0, 0, 8'h00, 0, 0, 4, 6, 8'h04, 1, 8'h11, 0, 8'h04);

        // Reset values after three reset cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_rdata_b", 32'(rdata_b), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("init_ready_%0d", i), 32'(ready), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("init_ready_nb", 32'(nb_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk($sformatf("init_a_%0d", i), 32'(rdata_a), (i == 0) ? 32'd0 : 32'(i));
            chk($sformatf("init_b_%0d", i), 32'(rdata_b), (i == 7) ? 32'd0 : 32'(7 - i));
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we = tv[i].we; waddr = tv[i].waddr; wdata = tv[i].wdata;
            rsv_en = tv[i].rsv_en; rsv_addr = tv[i].rsv_addr;
            raddr_a = tv[i].ra; raddr_b = tv[i].rb;
            #1;
            chk($sformatf("tv%0d_rdata_a", i), 32'(rdata_a), 32'(tv[i].ea));
            chk($sformatf("tv%0d_busy_a", i), 32'(busy_a), 32'(tv[i].eba));
            chk($sformatf("tv%0d_rdata_b", i), 32'(rdata_b), 32'(tv[i].eb));
            chk($sformatf("tv%0d_busy_b", i), 32'(busy_b), 32'(tv[i].ebb));
            chk($sformatf("tv%0d_nobyp_a", i), 32'(nb_rdata_a), 32'(tv[i].enb));
            @(posedge clk);
        end

        // Reset mid-operation with regs 2 and 4 reserved and reg 6 overwritten
        @(negedge clk);
        we = 1'b0; rsv_en = 1'b0; rst = 1'b1; raddr_a = 3'd2; raddr_b = 3'd4;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_busy_a", 32'(busy_a), 32'd0);
        chk("midrst_busy_b", 32'(busy_b), 32'd0);
        chk("midrst_rdata_a", 32'(rdata_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; waddr = 3'd1; wdata = 8'hEE; rsv_en = 1'b1; rsv_addr = 3'd3;
        repeat (8) @(posedge clk);
        @(negedge clk);
        we = 1'b0; rsv_en = 1'b0; raddr_a = 3'd6; raddr_b = 3'd2;
        #1;
        chk("reinit_ready", 32'(ready), 32'd1);
        chk("reinit_reg6", 32'(rdata_a), 32'd6);
        chk("reinit_busy2", 32'(busy_b), 32'd0);
        @(negedge clk);
        raddr_a = 3'd1; raddr_b = 3'd3;
        #1;
        chk("drop_we_reg1", 32'(rdata_a), 32'd1);
        chk("drop_rsv_busy3", 32'(busy_b), 32'd0);
        chk("reinit_reg3", 32'(rdata_b), 32'd3);

        // Random traffic against the reference model
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = 8'(i);
            m_busy[i] = 1'b0;
        end
        m_init_left = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            we = 1'($urandom_range(0, 1));
            rsv_en = ($urandom_range(0, 2) == 0);
            waddr = 3'($urandom_range(0, 7));
            rsv_addr = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            #1;
            chk("rnd_ready", 32'(ready), (m_init_left == 0) ? 32'd1 : 32'd0);
            model_read(raddr_a, 1'b1, ed, eb);
            chk("rnd_rdata_a", 32'(rdata_a), 32'(ed));
            chk("rnd_busy_a", 32'(busy_a), 32'(eb));
            model_read(raddr_b, 1'b1, ed, eb);
            chk("rnd_rdata_b", 32'(rdata_b), 32'(ed));
            chk("rnd_busy_b", 32'(busy_b), 32'(eb));
            model_read(raddr_a, 1'b0, ed, eb);
            chk("rnd_nobyp_a", 32'(nb_rdata_a), 32'(ed));
            chk("rnd_nobyp_busy_a", 32'(nb_busy_a), 32'(eb));
            @(posedge clk);
            if (rst) begin
                m_init_left = 8;
                for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
            end else if (m_init_left > 0) begin
                m_mem[8 - m_init_left] = 8'(8 - m_init_left);
                m_init_left--;
            end else begin
                if (we && waddr != 3'd0) begin
                    m_mem[waddr] = wdata;
                    m_busy[waddr] = 1'b0;
                end
                if (rsv_en && rsv_addr != 3'd0) m_busy[rsv_addr] = 1'b1;
            end
        end
        @(negedge clk);
        rst = 1'b0; we = 1'b0; rsv_en = 1'b0;

        // 32x32 variant with clearing init
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (i >= 31) chk($sformatf("w_ready_%0d", i), 32'(w_ready), (i == 32) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            w_raddr_a = 5'(i); w_raddr_b = 5'(31 - i);
            #1;
            chk($sformatf("w_zero_%0d", i), w_rdata_a | w_rdata_b, 32'd0);
        end
        @(negedge clk);
        w_we = 1'b1; w_waddr = 5'd31; w_wdata = 32'hDEADBEEF; w_raddr_a = 5'd31; w_raddr_b = 5'd1;
        #1;
        chk("w_bypass_a", w_rdata_a, 32'hDEADBEEF);
        chk("w_other_b", w_rdata_b, 32'd0);
        @(negedge clk);
        w_waddr = 5'd1; w_wdata = 32'h12345678;
        @(negedge clk);
        w_we = 1'b0; w_rsv_en = 1'b1; w_rsv_addr = 5'd1;
        #1;
        chk("w_dual_a31", w_rdata_a, 32'hDEADBEEF);
        chk("w_dual_b1", w_rdata_b, 32'h12345678);
        @(negedge clk);
        w_rsv_en = 1'b0;
        #1;
        chk("w_busy_b1", 32'(w_busy_b), 32'd1);
        chk("w_busy_a31", 32'(w_busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file for the pipelined RISC-V datapath, the successor to the current single-read 8×8 register file. A sequenced post-reset initialisation replaces the parallel reset load. The block adds optional x0 hardwiring, write-to-read bypass, and a per-register busy scoreboard that the decode stage uses for hazard detection. It sits between decode (read and reserve) and write-back (write).

## Interface
- DATA_W, 8: register width in bits
- NUM_REGS, 8: register count; power of two, ≥2
- ADDR_W, $clog2(NUM_REGS): address width
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes, never busy
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports
- INIT_MODE, 0: 0 = register i initialised to value i; 1 = all registers initialised to 0
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- raddr_a, raddr_b  in  ADDR_W  read addresses
- rdata_a, rdata_b  out  DATA_W  combinational read data
- busy_a, busy_b  out  1  scoreboard bit of raddr_a / raddr_b
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- ready  out  1  initialisation complete; block accepts traffic

## Operation
- FSM states:
  - INIT: a counter steps 0..NUM_REGS-1, writing the init value to one register per cycle.
  - RUN: normal operation.
- rst=1 at a clock edge: state←INIT, cnt←0, all busy bits←0. Array contents are left to the sequencer.
- INIT, rst=0: write reg[cnt] with cnt (INIT_MODE=0) or 0 (INIT_MODE=1) zero-extended/truncated to DATA_W, then cnt←cnt+1. After writing reg[NUM_REGS-1], go to RUN.
- ready=1 only in RUN.
- While ready=0:
  - rdata_a/b=0, busy_a/b=0.
  - we and rsv_en are ignored and dropped, not queued.
- RUN, write: on a rising edge with we=1, reg[waddr]←wdata and busy[waddr]←0. With ZERO_REG=1 and waddr=0, nothing changes.
- RUN, reserve: rsv_en=1 sets busy[rsv_addr]←1. Ignored for address 0 when ZERO_REG=1.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (the new producer wins).
- Read: rdata_x = reg[raddr_x]; 0 if ZERO_REG and raddr_x=0.
- BYPASS=1 and we=1, waddr=raddr_x, address legal for writing: rdata_x=wdata and busy_x=0 in the same cycle.
- BYPASS=0: the new value is visible only after the edge.
- Both read ports are independent; identical addresses return identical data.
- Reset mid-INIT or mid-RUN: the sequence restarts from cnt=0 and all busy bits are cleared.

## Timing
- Reads are combinational (zero latency) from raddr, we, waddr, wdata, and state.
- Writes and reservations take effect at the rising edge. The register value is visible to non-bypassed reads in the next cycle.
- Init latency: ready rises NUM_REGS cycles after the first edge with rst=0. With the default of 8, ready=1 in the 9th cycle after rst deasserts.
- Reset values: ready=0, busy_a/b=0, rdata_a/b=0.
- No handshake backpressure. The upstream must hold off we/rsv_en until ready=1.

## Structure
- Shared package: FSM state enum (ST_INIT, ST_RUN) and a function init_value(index, mode).
- Sub-module: `regfile_init_seq`, holding the INIT counter and FSM and emitting init_we, init_addr, init_data, and ready. The array, bypass muxes, and scoreboard stay in the top level.
- Write-port mux: init_* during INIT, we/waddr/wdata during RUN.

## Test plan
- Reset then init, defaults: hold rst 3 cycles, release → ready=0 for 8 cycles, then 1; reading regs 0..7 returns 0..7 in RUN.
- Write and bypass: we=1, waddr=3, wdata=8'hA5, raddr_a=3 → rdata_a=A5 in the same cycle (BYPASS=1). With BYPASS=0, rdata_a=3 that cycle and A5 the next.
- x0 hardwire: write 8'hFF to reg 0, rsv_en on 0 → rdata=0, busy=0 afterwards.
- Scoreboard: reserve reg 5 → busy_b=1 with raddr_b=5. A later write of 8'h3C to reg 5 → busy_b=0 and rdata_b=3C. Reserve and write reg 5 in the same cycle → busy stays 1.
- Reset mid-operation: reserve regs 2 and 4 and write 8'h11 to reg 6, assert rst 1 cycle → busy all 0, ready=0, and after re-init reg 6 reads 6.
- Parameter sweep: DATA_W=32, NUM_REGS=32, INIT_MODE=1 → ready after 32 cycles, all registers 0, dual reads of regs 31 and 1 independent.
